// File: rtl/he_pkg.sv
// Shared constants for the histogram-equalization engine and its frame sequencer.
package he_pkg;

   localparam int HE_IMG_W      = 660;
   localparam int HE_IMG_H      = 440;
   localparam int HE_NUM_PIXELS = HE_IMG_W * HE_IMG_H;
   localparam int HE_ADDR_W     = 19;
   localparam int NUM_BINS      = 256;
   localparam int PIX_W         = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_HIST   = 3'd2,
      S_HDRAIN = 3'd3,
      S_BUILD  = 3'd4,
      S_MAP    = 3'd5,
      S_FLUSH  = 3'd6
   } he_state_t;

endpackage

// File: rtl/he_out_fifo.sv
// Small synchronous FIFO with occupancy count; head reads as zero when empty.
module he_out_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!w_full || w_pop);
   assign o_dout  = o_empty ? '0 : r_mem[r_rp];
   assign o_count = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end

endmodule

// File: rtl/he_frame_ctrl.sv
// Two-pass frame sequencer: histogram pass, table build, then credited map pass
// into an output FIFO.
module he_frame_ctrl
   import he_pkg::*;
#(
   parameter int IMG_W      = HE_IMG_W,
   parameter int IMG_H      = HE_IMG_H,
   parameter int ADDR_W     = HE_ADDR_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [PIX_W-1:0]  mem_rd_data,
   output logic              eng_clear,
   output logic              eng_hist_valid,
   output logic              eng_build_start,
   input  logic              eng_build_done,
   output logic              eng_map_valid,
   output logic [PIX_W-1:0]  eng_pixel,
   input  logic              eng_map_out_valid,
   input  logic [PIX_W-1:0]  eng_map_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_pixel
);

   localparam int NUM_PIXELS = IMG_W * IMG_H;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   he_state_t         r_state;
   he_state_t         w_next;
   logic [ADDR_W-1:0] r_rd_cnt;
   logic [1:0]        r_inflight;
   logic              r_hist_v;
   logic              r_map_v;
   logic              r_bs;
   logic [CW-1:0]     w_fcount;
   logic              w_empty;
   logic              w_credit;
   logic              w_last;
   logic              w_issue;

   assign w_last   = (r_rd_cnt == ADDR_W'(NUM_PIXELS - 1));
   assign w_credit = (int'(r_inflight) + int'(w_fcount)) < FIFO_DEPTH;
   assign w_issue  = mem_rd_en && (r_state == S_MAP);

   always_comb begin
      w_next    = r_state;
      mem_rd_en = 1'b0;
      eng_clear = 1'b0;
      done      = 1'b0;
      unique case (r_state)
         S_IDLE:   if (start) w_next = S_CLEAR;
         S_CLEAR: begin
            eng_clear = 1'b1;
            w_next    = S_HIST;
         end
         S_HIST: begin
            mem_rd_en = 1'b1;
            if (w_last) w_next = S_HDRAIN;
         end
         S_HDRAIN: w_next = S_BUILD;
         // the build_start cycle is skipped so a level left over from the
         // previous table cannot be mistaken for this build's completion
         S_BUILD:  if (eng_build_done && !r_bs) w_next = S_MAP;
         S_MAP: begin
            mem_rd_en = w_credit;
            if (w_credit && w_last) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            if (r_inflight == 2'd0 && w_fcount == CW'(1) && out_ready) begin
               done   = 1'b1;
               w_next = S_IDLE;
            end
         end
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rd_cnt   <= '0;
         r_inflight <= '0;
         r_hist_v   <= 1'b0;
         r_map_v    <= 1'b0;
         r_bs       <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_hist_v <= mem_rd_en && (r_state == S_HIST);
         r_map_v  <= w_issue;
         r_bs     <= (r_state == S_HDRAIN);
         if (r_state == S_CLEAR || (r_state == S_BUILD && w_next == S_MAP))
            r_rd_cnt <= '0;
         else if (mem_rd_en)
            r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
         unique case ({w_issue, eng_map_out_valid})
            2'b10:   r_inflight <= r_inflight + 2'd1;
            2'b01:   r_inflight <= r_inflight - 2'd1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign busy            = (r_state != S_IDLE) && !done;
   assign mem_rd_addr     = r_rd_cnt;
   assign eng_hist_valid  = r_hist_v;
   assign eng_map_valid   = r_map_v;
   assign eng_build_start = r_bs;
   assign eng_pixel       = (r_hist_v || r_map_v) ? mem_rd_data : '0;
   assign out_valid       = !w_empty;

   he_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (eng_map_out_valid),
      .i_din   (eng_map_out),
      .i_pop   (out_ready),
      .o_dout  (out_pixel),
      .o_empty (w_empty),
      .o_count (w_fcount)
   );

endmodule

// File: tb/tb_he_frame_ctrl.sv
// Directed bench for he_frame_ctrl on a 4x2 frame with a behavioural engine
// and pixel memory.
module tb_he_frame_ctrl;

   localparam int NPIX = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        mem_rd_en;
   logic [18:0] mem_rd_addr;
   logic [7:0]  mem_rd_data;
   logic        eng_clear;
   logic        eng_hist_valid;
   logic        eng_build_start;
   logic        eng_build_done;
   logic        eng_map_valid;
   logic [7:0]  eng_pixel;
   logic        eng_map_out_valid;
   logic [7:0]  eng_map_out;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_pixel;

   always #5 clk = ~clk;

   he_frame_ctrl #(
      .IMG_W(4), .IMG_H(2), .ADDR_W(19), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .eng_clear(eng_clear),
      .eng_hist_valid(eng_hist_valid), .eng_build_start(eng_build_start),
      .eng_build_done(eng_build_done), .eng_map_valid(eng_map_valid),
      .eng_pixel(eng_pixel), .eng_map_out_valid(eng_map_out_valid),
      .eng_map_out(eng_map_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_pixel(out_pixel)
   );

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // pixel memory, 1-cycle read latency
   logic [7:0] mem [NPIX];
   always @(posedge clk)
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[2:0]];

   // engine model: histogram, table = floor(cdf*255/N) or pixel*2
   int         map_mode = 0;
   int         build_delay = 3;
   bit         bd_force = 1'b0;
   int         bd_cnt = 0;
   int         ehist [256];
   logic [7:0] lut [256];

   function automatic int cdf_e(input int v);
      int s = 0;
      for (int k = 0; k <= v; k++) s += ehist[k];
      return s;
   endfunction

   always @(posedge clk) begin
      if (eng_clear)
         for (int v = 0; v < 256; v++) ehist[v] <= 0;
      else if (eng_hist_valid)
         ehist[eng_pixel] <= ehist[eng_pixel] + 1;
      if (eng_build_start)
         for (int v = 0; v < 256; v++) lut[v] <= 8'(cdf_e(v) * 255 / NPIX);
      if (eng_build_start) bd_cnt <= build_delay;
      else if (bd_cnt > 0) bd_cnt <= bd_cnt - 1;
      eng_map_out_valid <= eng_map_valid;
      eng_map_out <= (map_mode == 0) ? 8'(eng_pixel << 1) : lut[eng_pixel];
   end
   assign eng_build_done = (bd_cnt == 1) || bd_force;

   // monitor
   bit         clr = 1'b0;
   int         cyc = 0;
   int         ph, n_hist, n_clear, n_bs, n_done, n_mrd, n_stall;
   int         last_h, last_m, cyc_bd, cyc_map1, max_cnt;
   logic [7:0] hist_q [$];
   logic [7:0] out_q [$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (clr) begin
         ph <= 0; n_hist <= 0; n_clear <= 0; n_bs <= 0; n_done <= 0;
         n_mrd <= 0; n_stall <= 0; last_h <= -1; last_m <= -1;
         cyc_bd <= -1; cyc_map1 <= -1; max_cnt <= 0;
         hist_q.delete();
         out_q.delete();
      end else if (!reset) begin
         if (eng_clear) n_clear <= n_clear + 1;
         if (eng_build_start) begin
            n_bs <= n_bs + 1;
            ph <= 1;
         end
         if (eng_hist_valid) begin
            n_hist <= n_hist + 1;
            hist_q.push_back(eng_pixel);
         end
         if (mem_rd_en && ph == 0) last_h <= int'(mem_rd_addr);
         if (ph == 1) begin
            if (mem_rd_en) begin
               ph <= 2;
               cyc_map1 <= cyc;
            end else if (eng_build_done && cyc_bd < 0) cyc_bd <= cyc;
         end
         if (mem_rd_en && ph != 0) begin
            last_m <= int'(mem_rd_addr);
            n_mrd <= n_mrd + 1;
         end
         if (ph == 2 && !mem_rd_en && n_mrd < NPIX) n_stall <= n_stall + 1;
         if (out_valid && out_ready) out_q.push_back(out_pixel);
         if (done) n_done <= n_done + 1;
         if (int'(dut.w_fcount) > max_cnt) max_cnt <= int'(dut.w_fcount);
      end
   end

   function automatic int exp_pix(input int j, input int m);
      int c = 0;
      if (m == 0) return (int'(mem[j]) * 2) & 255;
      for (int k = 0; k < NPIX; k++) if (mem[k] <= mem[j]) c++;
      return c * 255 / NPIX;
   endfunction

   task automatic clear_mon();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
   endtask

   task automatic run_frame(input int rmode, input int bdly, input bit mid,
                            input bit stale, input int mmode);
      bit ok = 1'b0;
      build_delay = bdly;
      map_mode = mmode;
      clear_mon();
      start = 1'b1;
      bd_force = stale;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         out_ready = (rmode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         start = mid && (n_hist == 3);
         if (stale && n_hist >= 4) bd_force = 1'b0;
         if (n_done != 0) begin
            ok = 1'b1;
            break;
         end
      end
      start = 1'b0;
      bd_force = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("frame_done_seen", int'(ok), 1);
   endtask

   typedef struct {
      int rmode;
      int bdly;
      bit mid;
      bit stale;
      bit rnd;
      int mmode;
      int exp_sum;
      int min_stall;
   } vec_t;

   vec_t tbl [6];

   task automatic check_frame(input vec_t v);
      int he = 0;
      int oe = 0;
      int sum = 0;
      for (int j = 0; j < NPIX; j++)
         if (j >= hist_q.size() || hist_q[j] != mem[j]) he++;
      for (int j = 0; j < NPIX; j++) begin
         if (j >= out_q.size() || int'(out_q[j]) != exp_pix(j, v.mmode)) oe++;
         if (j < out_q.size()) sum += int'(out_q[j]);
      end
      chk("hist_beats", n_hist, NPIX);
      chk("hist_data_err", he, 0);
      chk("clear_pulses", n_clear, 1);
      chk("build_pulses", n_bs, 1);
      chk("done_pulses", n_done, 1);
      chk("out_count", out_q.size(), NPIX);
      chk("out_data_err", oe, 0);
      chk("map_start_lat", cyc_map1 - cyc_bd, 1);
      chk("last_hist_addr", last_h, NPIX - 1);
      chk("last_map_addr", last_m, NPIX - 1);
      chk("fifo_max_le4", int'(max_cnt <= 4), 1);
      chk("busy_after", int'(busy), 0);
      if (v.exp_sum >= 0) chk("out_sum", sum, v.exp_sum);
      if (v.min_stall > 0) chk("rd_stalls", int'(n_stall >= v.min_stall), 1);
   endtask

   initial begin
      tbl[0] = '{0,  3, 1'b0, 1'b0, 1'b0, 0, 56, 0};
      tbl[1] = '{1,  3, 1'b0, 1'b0, 1'b0, 0, 56, 2};
      tbl[2] = '{0, 50, 1'b0, 1'b0, 1'b0, 0, 56, 0};
      tbl[3] = '{0,  3, 1'b1, 1'b0, 1'b0, 0, 56, 0};
      tbl[4] = '{0,  5, 1'b0, 1'b1, 1'b0, 0, 56, 0};
      tbl[5] = '{0,  4, 1'b0, 1'b0, 1'b1, 1, -1, 0};

      reset = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      mem_rd_data = '0;
      eng_map_out_valid = 1'b0;
      eng_map_out = '0;
      for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
      repeat (3) @(negedge clk);
      chk("reset_outs", int'(|{busy, done, mem_rd_en, mem_rd_addr, eng_clear,
          eng_hist_valid, eng_build_start, eng_map_valid, eng_pixel,
          out_valid, out_pixel}), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < NPIX; j++)
            mem[j] = tbl[i].rnd ? 8'($urandom_range(0, 255)) : 8'(j);
         run_frame(tbl[i].rmode, tbl[i].bdly, tbl[i].mid, tbl[i].stale,
                   tbl[i].mmode);
         check_frame(tbl[i]);
      end

      // abort in MAP after three outputs, then a clean frame
      for (int j = 0; j < NPIX; j++) mem[j] = 8'(j);
      map_mode = 0;
      build_delay = 3;
      clear_mon();
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 500; k++) begin
         if (out_q.size() >= 3) break;
         @(negedge clk);
      end
      chk("abort_reached", out_q.size(), 3);
      reset = 1'b1;
      #1;
      chk("abort_outs", int'(|{busy, done, mem_rd_en, mem_rd_addr, eng_clear,
          eng_hist_valid, eng_build_start, eng_map_valid, eng_pixel,
          out_valid, out_pixel}), 0);
      chk("abort_state", int'(dut.r_state), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_no_done", n_done, 0);
      run_frame(0, 3, 1'b0, 1'b0, 0);
      check_frame(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
